// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller and CP0 block:
// ExcCodes, request-vector bit positions, FSM encoding, SR bit index.
package exc_pkg;

    // MIPS ExcCode values written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Request vector layout, bit 7 is the highest priority source
    localparam int REQ_W       = 8;
    localparam int REQ_INT     = 7;
    localparam int REQ_ADEL_IF = 6;
    localparam int REQ_RI      = 5;
    localparam int REQ_OV      = 4;
    localparam int REQ_SYS     = 3;
    localparam int REQ_BP      = 2;
    localparam int REQ_ADEL_LD = 1;
    localparam int REQ_ADES_ST = 0;

    // Controller FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    // Status register EXL bit position, shared with the CP0 register file
    localparam int SR_EXL_BIT = 1;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: picks the highest priority exception source
// and returns its ExcCode. Interrupts are masked while EXL is set.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    input  logic             status_exl,
    output logic             valid,
    output logic [4:0]       code
);

    // Priority chain, highest first; synchronous sources ignore EXL
    always_comb begin
        valid = 1'b1;
        code  = EXC_INT;
        if (req[REQ_INT] && !status_exl) code = EXC_INT;
        else if (req[REQ_ADEL_IF])       code = EXC_ADEL;
        else if (req[REQ_RI])            code = EXC_RI;
        else if (req[REQ_OV])            code = EXC_OV;
        else if (req[REQ_SYS])           code = EXC_SYS;
        else if (req[REQ_BP])            code = EXC_BP;
        else if (req[REQ_ADEL_LD])       code = EXC_ADEL;
        else if (req[REQ_ADES_ST])       code = EXC_ADES;
        else                             valid = 1'b0;
    end

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception/ERET controller: arbitrates sources, pulses the
// CP0 update, holds flush for FLUSH_CYCLES, then redirects fetch to the
// handler vector or to EPC.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        exc_int,
    input  logic        exc_adel_if,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_adel_ld,
    input  logic        exc_ades_st,
    input  logic        eret,
    input  logic        status_exl,
    input  logic [31:0] epc,
    output logic        exception,
    output logic [4:0]  exc_code,
    output logic [31:0] exception_pc,
    output logic        exl_clear,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic [1:0]       state;
    logic [2:0]       cnt;
    logic             is_eret;
    logic [31:0]      epc_lat;
    logic [REQ_W-1:0] req;
    logic             exc_valid;
    logic [4:0]       win_code;
    logic             take_exc;
    logic             take_eret;

    assign req = {exc_int, exc_adel_if, exc_ri, exc_ov,
                  exc_sys, exc_bp, exc_adel_ld, exc_ades_st};

    exc_prio_enc u_prio (
        .req        (req),
        .status_exl (status_exl),
        .valid      (exc_valid),
        .code       (win_code)
    );

    // Events are only accepted from a committing instruction while idle;
    // an exception always beats a simultaneous ERET
    assign take_exc  = (state == ST_IDLE) && commit_valid && exc_valid;
    assign take_eret = (state == ST_IDLE) && commit_valid && eret && !exc_valid;

    // FSM, flush counter and registered outputs; pulses default low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            cnt            <= 3'd0;
            is_eret        <= 1'b0;
            epc_lat        <= 32'd0;
            exception      <= 1'b0;
            exc_code       <= 5'd0;
            exception_pc   <= 32'd0;
            exl_clear      <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            exception      <= 1'b0;
            exl_clear      <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_exc) begin
                        exception    <= 1'b1;
                        exc_code     <= win_code;
                        exception_pc <= commit_pc;
                        flush        <= 1'b1;
                        is_eret      <= 1'b0;
                        cnt          <= 3'(FLUSH_CYCLES);
                        state        <= ST_FLUSH;
                    end else if (take_eret) begin
                        exl_clear    <= 1'b1;
                        flush        <= 1'b1;
                        is_eret      <= 1'b1;
                        cnt          <= 3'(FLUSH_CYCLES);
                        state        <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // EPC is taken in the first flush cycle (the exl_clear cycle)
                    if (exl_clear) epc_lat <= epc;
                    if (cnt <= 3'd1) begin
                        cnt            <= 3'd0;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                        if (is_eret) redirect_pc <= exl_clear ? epc : epc_lat;
                        else         redirect_pc <= HANDLER_PC;
                        state          <= ST_REDIRECT;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_REDIRECT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        exc_int, exc_adel_if, exc_ri, exc_ov;
    logic        exc_sys, exc_bp, exc_adel_ld, exc_ades_st;
    logic        eret;
    logic        status_exl;
    logic [31:0] epc;
    logic        exception;
    logic [4:0]  exc_code;
    logic [31:0] exception_pc;
    logic        exl_clear;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errs   = 0;
    int checks = 0;

    // tallies gathered by observe()
    int          n_exc, n_clr, n_flush, n_redir;
    logic [4:0]  last_code;
    logic [31:0] last_rpc;

    always #5 clk = ~clk;

    exception_ctrl #(.HANDLER_PC(32'hBFC0_0380), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .exc_int        (exc_int),
        .exc_adel_if    (exc_adel_if),
        .exc_ri         (exc_ri),
        .exc_ov         (exc_ov),
        .exc_sys        (exc_sys),
        .exc_bp         (exc_bp),
        .exc_adel_ld    (exc_adel_ld),
        .exc_ades_st    (exc_ades_st),
        .eret           (eret),
        .status_exl     (status_exl),
        .epc            (epc),
        .exception      (exception),
        .exc_code       (exc_code),
        .exception_pc   (exception_pc),
        .exl_clear      (exl_clear),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_in();
        commit_valid = 1'b0;
        exc_int = 1'b0; exc_adel_if = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0;
        exc_sys = 1'b0; exc_bp = 1'b0; exc_adel_ld = 1'b0; exc_ades_st = 1'b0;
        eret = 1'b0;
    endtask

    // req = {int, adel_if, ri, ov, sys, bp, adel_ld, ades_st}
    task automatic apply(input logic [31:0] pc, input logic [7:0] req,
                         input logic er, input logic exl);
        commit_valid = 1'b1;
        commit_pc    = pc;
        {exc_int, exc_adel_if, exc_ri, exc_ov,
         exc_sys, exc_bp, exc_adel_ld, exc_ades_st} = req;
        eret         = er;
        status_exl   = exl;
    endtask

    // Count pulses over the next n cycles; inputs are dropped after the first edge
    task automatic observe(input int n);
        n_exc = 0; n_clr = 0; n_flush = 0; n_redir = 0;
        last_code = 5'h1f; last_rpc = 32'hDEAD_BEEF;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_in();
            if (exception)      begin n_exc++; last_code = exc_code; end
            if (exl_clear)      n_clr++;
            if (flush)          n_flush++;
            if (redirect_valid) begin n_redir++; last_rpc = redirect_pc; end
        end
    endtask

    task automatic exc_case(input string tag, input logic [7:0] req,
                            input logic er, input logic exl, input logic [4:0] code);
        @(negedge clk);
        apply(32'h0000_4000, req, er, exl);
        observe(6);
        chk({tag, "_npulse"}, 32'(n_exc), 32'd1);
        chk({tag, "_code"},   32'(last_code), 32'(code));
        chk({tag, "_clr"},    32'(n_clr), 32'd0);
    endtask

    initial begin
        clear_in();
        commit_pc  = 32'd0;
        status_exl = 1'b0;
        epc        = 32'd0;
        rstn       = 1'b0;
        @(negedge clk);
        chk("rst_exc",   32'(exception), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rv",    32'(redirect_valid), 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);
        chk("rst_code",  32'(exc_code), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Overflow, cycle-exact timing
        apply(32'h0000_1000, 8'b0001_0000, 1'b0, 1'b0);
        @(negedge clk); clear_in();
        chk("ov_exc",   32'(exception), 32'd1);
        chk("ov_code",  32'(exc_code), 32'd12);
        chk("ov_pc",    exception_pc, 32'h0000_1000);
        chk("ov_fl1",   32'(flush), 32'd1);
        chk("ov_rv1",   32'(redirect_valid), 32'd0);
        @(negedge clk);
        chk("ov_exc2",  32'(exception), 32'd0);
        chk("ov_fl2",   32'(flush), 32'd1);
        chk("ov_code2", 32'(exc_code), 32'd12);
        @(negedge clk);
        chk("ov_fl3",   32'(flush), 32'd0);
        chk("ov_rv",    32'(redirect_valid), 32'd1);
        chk("ov_rpc",   redirect_pc, 32'hBFC0_0380);
        @(negedge clk);
        chk("ov_rv_off", 32'(redirect_valid), 32'd0);
        chk("ov_rpc_hold", redirect_pc, 32'hBFC0_0380);
        chk("ov_pc_hold", exception_pc, 32'h0000_1000);

        // Priority cases
        exc_case("ri_ov_sys", 8'b0011_1000, 1'b0, 1'b0, 5'd10);
        exc_case("int_ri_exl", 8'b1010_0000, 1'b0, 1'b1, 5'd10);
        exc_case("int_noexl", 8'b1000_0000, 1'b0, 1'b0, 5'd0);
        exc_case("adelif_ri", 8'b0110_0000, 1'b0, 1'b0, 5'd4);
        exc_case("sys_bp",    8'b0000_1100, 1'b0, 1'b0, 5'd8);
        exc_case("adel_ld",   8'b0000_0011, 1'b0, 1'b0, 5'd4);
        exc_case("ades_st",   8'b0000_0001, 1'b0, 1'b0, 5'd5);
        exc_case("eret_bp",   8'b0000_0100, 1'b1, 1'b1, 5'd9);

        // Int alone while EXL set: ignored
        @(negedge clk);
        apply(32'h0000_4000, 8'b1000_0000, 1'b0, 1'b1);
        observe(6);
        chk("intmask_exc",   32'(n_exc), 32'd0);
        chk("intmask_flush", 32'(n_flush), 32'd0);
        chk("intmask_redir", 32'(n_redir), 32'd0);

        // ERET
        epc = 32'h0000_2004;
        @(negedge clk);
        apply(32'h0000_5000, 8'b0, 1'b1, 1'b1);
        observe(6);
        chk("eret_clr",   32'(n_clr), 32'd1);
        chk("eret_exc",   32'(n_exc), 32'd0);
        chk("eret_flush", 32'(n_flush), 32'd2);
        chk("eret_redir", 32'(n_redir), 32'd1);
        chk("eret_rpc",   last_rpc, 32'h0000_2004);
        status_exl = 1'b0;

        // Second exception during FLUSH is ignored
        @(negedge clk);
        apply(32'h0000_6000, 8'b0001_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("busy_exc", 32'(exception), 32'd1);
        apply(32'h0000_6004, 8'b0000_1000, 1'b0, 1'b0);
        observe(6);
        chk("busy_npulse", 32'(n_exc), 32'd0);
        chk("busy_redir",  32'(n_redir), 32'd1);
        chk("busy_code",   32'(exc_code), 32'd12);
        chk("busy_pc",     exception_pc, 32'h0000_6000);

        // Reset mid-flush aborts without redirect
        @(negedge clk);
        apply(32'h0000_7000, 8'b0000_1000, 1'b0, 1'b0);
        @(negedge clk); clear_in();
        chk("rstf_pre", 32'(flush), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rstf_flush", 32'(flush), 32'd0);
        chk("rstf_exc",   32'(exception), 32'd0);
        chk("rstf_code",  32'(exc_code), 32'd0);
        chk("rstf_rpc",   redirect_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        observe(6);
        chk("rstf_redir", 32'(n_redir), 32'd0);
        chk("rstf_fl",    32'(n_flush), 32'd0);

        // Syscall without commit_valid: no response
        @(negedge clk);
        apply(32'h0000_8000, 8'b0000_1000, 1'b0, 1'b0);
        commit_valid = 1'b0;
        observe(6);
        chk("nocv_exc",   32'(n_exc), 32'd0);
        chk("nocv_flush", 32'(n_flush), 32'd0);

        // Block still usable after the reset abort
        exc_case("post_rst", 8'b0000_1000, 1'b0, 1'b0, 5'd8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Producer side of the CP0 exception interface: collects exception conditions and ERET at the commit stage, arbitrates them by MIPS priority, and issues the one-cycle exception pulse, ExcCode and faulting PC into the CP0 register file.
- Sequences the resulting pipeline flush and the fetch redirect: to the handler vector on an exception, or to EPC on ERET.
- Sits between the MEM/commit stage, the CP0 register block and the fetch PC mux.

Parameters:
HANDLER_PC, 32'hBFC0_0380, exception vector loaded into fetch on exception
FLUSH_CYCLES, 2, number of cycles flush is held (1..7)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
commit_valid  in  1  an instruction is committing this cycle
commit_pc  in  32  PC of committing instruction
exc_int  in  1  external/timer interrupt pending
exc_adel_if  in  1  fetch address error
exc_ri  in  1  reserved instruction
exc_ov  in  1  arithmetic overflow
exc_sys  in  1  syscall
exc_bp  in  1  break
exc_adel_ld  in  1  load address error
exc_ades_st  in  1  store address error
eret  in  1  committing instruction is ERET
status_exl  in  1  SR.EXL from CP0
epc  in  32  EPC from CP0
exception  out  1  one-cycle pulse to CP0
exc_code  out  5  ExcCode to CP0
exception_pc  out  32  PC recorded into EPC
exl_clear  out  1  one-cycle pulse requesting SR.EXL clear on ERET
flush  out  1  kill all in-flight pipeline instructions
redirect_valid  out  1  one-cycle pulse: load redirect_pc into fetch
redirect_pc  out  32  new fetch PC

Behaviour:
- Reset (async, rstn=0): state=IDLE, flush counter=0, all outputs 0. Reset mid-flush aborts the sequence immediately; no redirect is issued.
- FSM states: IDLE, FLUSH, REDIRECT.
- Inputs are sampled only in IDLE with commit_valid=1. All exc_*/eret inputs are ignored in FLUSH/REDIRECT and when commit_valid=0.
- Interrupt masking: exc_int is effective only when status_exl=0. Synchronous exceptions are taken regardless of EXL.
- Priority, highest first, with ExcCode:
  - Int = 0
  - AdEL fetch = 4
  - RI = 10
  - Ov = 12
  - Sys = 8
  - Bp = 9
  - AdEL load = 4
  - AdES store = 5
- Exception at cycle N (IDLE, any effective source):
  - N+1: exception=1, exc_code=winner, exception_pc=commit_pc (registered), flush=1; state→FLUSH.
  - exception is high for exactly one cycle; exc_code/exception_pc hold their values until the next event.
- ERET at cycle N (IDLE, eret=1, no effective exception):
  - N+1: exl_clear=1 for one cycle, flush=1; state→FLUSH.
  - Return PC is epc sampled at N+1.
- Exception and eret in the same cycle: the exception wins and eret is dropped; no exl_clear.
- FLUSH: flush stays high for FLUSH_CYCLES consecutive cycles (N+1 .. N+FLUSH_CYCLES), counted by a 3-bit down-counter; then state→REDIRECT.
- REDIRECT, one cycle at N+FLUSH_CYCLES+1:
  - redirect_valid=1; flush=0.
  - redirect_pc = HANDLER_PC for an exception, or the latched epc for ERET.
  - state→IDLE.
  - redirect_pc holds its value afterwards.
- Back-to-back events: a new event is accepted at the earliest in the cycle after REDIRECT.
- No branch-delay-slot handling: exception_pc is always commit_pc.

Decomposition:
- Shared package exc_pkg:
  - ExcCode localparams: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV.
  - FSM state encoding: IDLE/FLUSH/REDIRECT.
  - SR EXL bit index, shared with the CP0 block.
- One combinational sub-module, exc_prio_enc: 8 request bits plus status_exl in → valid plus 5-bit code out.

Test Plan:
- Overflow at commit_pc=0x0000_1000, status_exl=0 → next cycle exception=1, exc_code=12, exception_pc=0x1000; flush high 2 cycles; then redirect_valid=1 with redirect_pc=0xBFC0_0380.
- RI+Ov+Sys asserted together → exc_code=10. Int+RI with status_exl=1 → exc_code=10. Int alone with status_exl=1 → no exception, no flush.
- ERET with epc=0x0000_2004 → exl_clear pulse, 2-cycle flush, redirect_pc=0x0000_2004. eret together with exc_bp → exc_code=9, exl_clear stays 0.
- New exception asserted during FLUSH → ignored; exactly one exception pulse and one redirect.
- rstn dropped during FLUSH → all outputs 0 immediately; after release the block is in IDLE with no redirect issued. Sys at commit_valid=0 → no response.
